// File: rtl/czonotope_pkg.sv
// Shared types and width helpers for the constrained-zonotope loader.
//  - wr_sel_e   : target array of a write (c, G, A, b)
//  - err_code_e : reason a frame was rejected
//  - ld_state_e : loader FSM states
//  - width helpers used to size row/column counters and dimension registers
package czonotope_pkg;

   typedef enum logic [1:0] {
      SEL_C = 2'd0,
      SEL_G = 2'd1,
      SEL_A = 2'd2,
      SEL_B = 2'd3
   } wr_sel_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_DIM   = 2'd1,
      ERR_SHORT = 2'd2,
      ERR_LONG  = 2'd3
   } err_code_e;

   typedef enum logic [3:0] {
      ST_HDR_N  = 4'd0,
      ST_HDR_NG = 4'd1,
      ST_HDR_NC = 4'd2,
      ST_LD_C   = 4'd3,
      ST_LD_G   = 4'd4,
      ST_LD_A   = 4'd5,
      ST_LD_B   = 4'd6,
      ST_DONE   = 4'd7,
      ST_DRAIN  = 4'd8
   } ld_state_e;

   // An index into an array of size 1 still needs a 1-bit port.
   function automatic int clog2_min1(input int v);
      int r;
      r = $clog2(v);
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int rw_width(input int nmax, input int ncmax);
      return clog2_min1((nmax > ncmax) ? nmax : ncmax);
   endfunction

   function automatic int cw_width(input int ngmax);
      return clog2_min1(ngmax);
   endfunction

   // Dimension registers must hold the maximum value itself, not just max-1.
   function automatic int dim_width(input int vmax);
      return $clog2(vmax) + 1;
   endfunction

endpackage

// File: rtl/czono_rc_counter.sv
// Row/column index generator for one load phase.
// Walks (row,col) in row-major order up to (row_lim,col_lim) and wraps back
// to (0,0) after the last element, so the next phase starts from zero.
// Ports:
//  clk, rst_n : clock, asynchronous active-low reset
//  clr        : force indices to (0,0)
//  step       : advance one element
//  row_lim    : last row index of the current phase
//  col_lim    : last column index of the current phase (0 for vectors)
//  row, col   : current element index
//  last       : current element is (row_lim,col_lim)
module czono_rc_counter #(
   parameter int RW = 9,
   parameter int CW = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          step,
   input  logic [RW-1:0] row_lim,
   input  logic [CW-1:0] col_lim,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic          last
);

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          col_wrap;

   assign col_wrap = (col_q == col_lim);
   assign last     = col_wrap && (row_q == row_lim);
   assign row      = row_q;
   assign col      = col_q;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr) begin
         row_d = '0;
         col_d = '0;
      end else if (step) begin
         if (last) begin
            row_d = '0;
            col_d = '0;
         end else if (col_wrap) begin
            row_d = row_q + 1'b1;
            col_d = '0;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/czonotope_loader.sv
// Stream-to-storage writer for constrained-zonotope data.
// Consumes a framed stream {n, ng, nc, c, G, A, b}, checks the dimensions and
// the frame length, and issues one registered indexed write per data word.
// Ports:
//  clk, rst_n                 : clock, asynchronous active-low reset
//  s_data/s_valid/s_ready     : input word stream (beat = s_valid & s_ready)
//  s_last                     : final word of a frame
//  wr_en/wr_sel/wr_row/wr_col : storage write strobe, target array and index
//  wr_data                    : storage write data
//  dim_n/dim_ng/dim_nc        : captured dimensions
//  dim_valid                  : storage holds a complete, checked frame
//  busy                       : frame in progress
//  done/err                   : one-cycle completion / rejection pulses
//  err_code                   : reason of the most recent rejection
module czonotope_loader
   import czonotope_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int NMAX       = 512,
   parameter  int NGMAX      = 512,
   parameter  int NCMAX      = 512,
   localparam int RW         = rw_width(NMAX, NCMAX),
   localparam int CW         = cw_width(NGMAX),
   localparam int NW         = dim_width(NMAX),
   localparam int NGW        = dim_width(NGMAX),
   localparam int NCW        = dim_width(NCMAX)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  s_last,
   output logic                  wr_en,
   output logic [1:0]            wr_sel,
   output logic [RW-1:0]         wr_row,
   output logic [CW-1:0]         wr_col,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic [NW-1:0]         dim_n,
   output logic [NGW-1:0]        dim_ng,
   output logic [NCW-1:0]        dim_nc,
   output logic                  dim_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [1:0]            err_code
);

   localparam logic [NW-1:0]  NMAX_V  = NW'(NMAX);
   localparam logic [NGW-1:0] NGMAX_V = NGW'(NGMAX);
   localparam logic [NCW-1:0] NCMAX_V = NCW'(NCMAX);

   ld_state_e             state_q, state_d;
   logic [NW-1:0]         dim_n_q, dim_n_d;
   logic [NGW-1:0]        dim_ng_q, dim_ng_d;
   logic [NCW-1:0]        dim_nc_q, dim_nc_d;
   logic                  dim_valid_q, dim_valid_d;
   logic                  wr_en_q, wr_en_d;
   wr_sel_e               wr_sel_q, wr_sel_d;
   logic [RW-1:0]         wr_row_q, wr_row_d;
   logic [CW-1:0]         wr_col_q, wr_col_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   err_code_e             err_code_q, err_code_d;

   logic                  beat;
   logic [NCW-1:0]        nc_in;
   logic                  dims_ok;
   logic                  cnt_clr, cnt_step, cnt_last;
   logic [RW-1:0]         cnt_row, row_lim;
   logic [CW-1:0]         cnt_col, col_lim;

   assign s_ready = (state_q != ST_DONE);
   assign beat    = s_valid && s_ready;
   assign busy    = (state_q != ST_HDR_N) && (state_q != ST_DONE);

   // nc arrives on the same beat as the check; n and ng are already registered.
   assign nc_in   = s_data[NCW-1:0];
   assign dims_ok = (dim_n_q != '0) && (dim_n_q <= NMAX_V) &&
                    (dim_ng_q != '0) && (dim_ng_q <= NGMAX_V) &&
                    (nc_in <= NCMAX_V);

   czono_rc_counter #(
      .RW (RW),
      .CW (CW)
   ) u_rc_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (cnt_clr),
      .step    (cnt_step),
      .row_lim (row_lim),
      .col_lim (col_lim),
      .row     (cnt_row),
      .col     (cnt_col),
      .last    (cnt_last)
   );

   always_comb begin
      state_d     = state_q;
      dim_n_d     = dim_n_q;
      dim_ng_d    = dim_ng_q;
      dim_nc_d    = dim_nc_q;
      dim_valid_d = dim_valid_q;
      wr_en_d     = 1'b0;
      wr_sel_d    = wr_sel_q;
      wr_row_d    = wr_row_q;
      wr_col_d    = wr_col_q;
      wr_data_d   = wr_data_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      cnt_clr     = 1'b0;
      cnt_step    = 1'b0;
      row_lim     = '0;
      col_lim     = '0;

      // Phase limits: c/G are n rows, A/b are nc rows; G/A are ng columns wide.
      unique case (state_q)
         ST_LD_C: row_lim = RW'(dim_n_q - 1'b1);
         ST_LD_G: begin
            row_lim = RW'(dim_n_q - 1'b1);
            col_lim = CW'(dim_ng_q - 1'b1);
         end
         ST_LD_A: begin
            row_lim = RW'(dim_nc_q - 1'b1);
            col_lim = CW'(dim_ng_q - 1'b1);
         end
         ST_LD_B: row_lim = RW'(dim_nc_q - 1'b1);
         default: ;
      endcase

      // Every data beat in a load phase becomes a write, including the
      // beat that ends the frame early or late.
      if (beat && (state_q inside {ST_LD_C, ST_LD_G, ST_LD_A, ST_LD_B})) begin
         cnt_step  = 1'b1;
         wr_en_d   = 1'b1;
         wr_row_d  = cnt_row;
         wr_col_d  = cnt_col;
         wr_data_d = s_data;
         unique case (state_q)
            ST_LD_C: wr_sel_d = SEL_C;
            ST_LD_G: wr_sel_d = SEL_G;
            ST_LD_A: wr_sel_d = SEL_A;
            default: wr_sel_d = SEL_B;
         endcase
      end

      unique case (state_q)
         ST_HDR_N: begin
            cnt_clr = 1'b1;
            if (beat) begin
               dim_n_d     = s_data[NW-1:0];
               dim_valid_d = 1'b0;
               if (s_last) begin
                  err_d = 1'b1; err_code_d = ERR_SHORT; state_d = ST_HDR_N;
               end else begin
                  state_d = ST_HDR_NG;
               end
            end
         end
         ST_HDR_NG: begin
            cnt_clr = 1'b1;
            if (beat) begin
               dim_ng_d = s_data[NGW-1:0];
               if (s_last) begin
                  err_d = 1'b1; err_code_d = ERR_SHORT; state_d = ST_HDR_N;
               end else begin
                  state_d = ST_HDR_NG == ST_HDR_NG ? ST_HDR_NC : ST_HDR_NC;
               end
            end
         end
         ST_HDR_NC: begin
            cnt_clr = 1'b1;
            if (beat) begin
               dim_nc_d = nc_in;
               if (!dims_ok) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_DIM;
                  state_d    = s_last ? ST_HDR_N : ST_DRAIN;
               end else if (s_last) begin
                  err_d = 1'b1; err_code_d = ERR_SHORT; state_d = ST_HDR_N;
               end else begin
                  state_d = ST_LD_C;
               end
            end
         end
         ST_LD_C: begin
            if (beat) begin
               // G always follows c, so s_last here is always early.
               if (s_last) begin
                  err_d = 1'b1; err_code_d = ERR_SHORT; state_d = ST_HDR_N;
               end else if (cnt_last) begin
                  state_d = ST_LD_G;
               end
            end
         end
         ST_LD_G: begin
            if (beat) begin
               if (cnt_last && (dim_nc_q == '0)) begin
                  // No constraints: the last G word closes the frame.
                  if (s_last) begin
                     state_d = ST_DONE; done_d = 1'b1; dim_valid_d = 1'b1;
                  end else begin
                     err_d = 1'b1; err_code_d = ERR_LONG; state_d = ST_DRAIN;
                  end
               end else if (s_last) begin
                  err_d = 1'b1; err_code_d = ERR_SHORT; state_d = ST_HDR_N;
               end else if (cnt_last) begin
                  state_d = ST_LD_A;
               end
            end
         end
         ST_LD_A: begin
            if (beat) begin
               if (s_last) begin
                  err_d = 1'b1; err_code_d = ERR_SHORT; state_d = ST_HDR_N;
               end else if (cnt_last) begin
                  state_d = ST_LD_B;
               end
            end
         end
         ST_LD_B: begin
            if (beat) begin
               if (cnt_last) begin
                  if (s_last) begin
                     state_d = ST_DONE; done_d = 1'b1; dim_valid_d = 1'b1;
                  end else begin
                     err_d = 1'b1; err_code_d = ERR_LONG; state_d = ST_DRAIN;
                  end
               end else if (s_last) begin
                  err_d = 1'b1; err_code_d = ERR_SHORT; state_d = ST_HDR_N;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_HDR_N;
         end
         ST_DRAIN: begin
            if (beat && s_last) begin
               state_d = ST_HDR_N;
            end
         end
         default: begin
            state_d = ST_HDR_N;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_HDR_N;
         dim_n_q     <= '0;
         dim_ng_q    <= '0;
         dim_nc_q    <= '0;
         dim_valid_q <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_sel_q    <= SEL_C;
         wr_row_q    <= '0;
         wr_col_q    <= '0;
         wr_data_q   <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         dim_n_q     <= dim_n_d;
         dim_ng_q    <= dim_ng_d;
         dim_nc_q    <= dim_nc_d;
         dim_valid_q <= dim_valid_d;
         wr_en_q     <= wr_en_d;
         wr_sel_q    <= wr_sel_d;
         wr_row_q    <= wr_row_d;
         wr_col_q    <= wr_col_d;
         wr_data_q   <= wr_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_sel    = wr_sel_q;
   assign wr_row    = wr_row_q;
   assign wr_col    = wr_col_q;
   assign wr_data   = wr_data_q;
   assign dim_n     = dim_n_q;
   assign dim_ng    = dim_ng_q;
   assign dim_nc    = dim_nc_q;
   assign dim_valid = dim_valid_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_czonotope_loader.sv
// Directed self-checking bench for czonotope_loader (default parameters).
module tb_czonotope_loader;

   logic        clk;
   logic        rst_n;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic        s_last;
   logic        wr_en;
   logic [1:0]  wr_sel;
   logic [8:0]  wr_row;
   logic [8:0]  wr_col;
   logic [31:0] wr_data;
   logic [9:0]  dim_n;
   logic [9:0]  dim_ng;
   logic [9:0]  dim_nc;
   logic        dim_valid;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;

   int checks   = 0;
   int failures = 0;

   // Write / pulse log filled by the monitor.
   logic [1:0]  w_sel  [0:63];
   logic [8:0]  w_row  [0:63];
   logic [8:0]  w_col  [0:63];
   logic [31:0] w_data [0:63];
   int wn = 0;
   int dn = 0;
   int en = 0;

   // Expected write order for n=2, ng=3, nc=1.
   int exp_sel [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 2, 2, 2, 3};
   int exp_row [12] = '{0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
   int exp_col [12] = '{0, 0, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0};

   czonotope_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_last    (s_last),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_row    (wr_row),
      .wr_col    (wr_col),
      .wr_data   (wr_data),
      .dim_n     (dim_n),
      .dim_ng    (dim_ng),
      .dim_nc    (dim_nc),
      .dim_valid (dim_valid),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en) begin
            w_sel[wn[5:0]]  <= wr_sel;
            w_row[wn[5:0]]  <= wr_row;
            w_col[wn[5:0]]  <= wr_col;
            w_data[wn[5:0]] <= wr_data;
            wn <= wn + 1;
         end
         if (done) dn <= dn + 1;
         if (err)  en <= en + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One accepted beat; waits (bounded) while the loader is not ready.
   task automatic beat(input logic [31:0] d, input logic l);
      bit ok;
      ok      = 1'b0;
      s_data  = d;
      s_valid = 1'b1;
      s_last  = l;
      for (int i = 0; i < 8 && !ok; i++) begin
         ok = s_ready;
         @(posedge clk);
         #1;
      end
      checks++;
      assert (ok) else begin
         failures++;
         $error("FAIL beat_timeout observed=not_accepted expected=accepted");
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic idle(input int k);
      s_valid = 1'b0;
      repeat (k) @(posedge clk);
      #1;
   endtask

   initial begin
      int w0, d0, e0, idx;
      rst_n   = 1'b0;
      s_data  = '0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_err_code", 32'(err_code), 0);
      chk("rst_dim_valid", 32'(dim_valid), 0);
      chk("rst_dim_n", 32'(dim_n), 0);
      chk("rst_s_ready", 32'(s_ready), 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Frame 1: n=2 ng=3 nc=1
      w0 = wn; d0 = dn;
      beat(32'd2, 1'b0); beat(32'd3, 1'b0); beat(32'd1, 1'b0);
      for (int k = 0; k < 12; k++) beat(32'hD000 + 32'(k), k == 11);
      repeat (2) @(negedge clk);
      chk("t1_writes", wn - w0, 12);
      for (int k = 0; k < 12; k++) begin
         idx = w0 + k;
         chk($sformatf("t1_sel%0d", k), 32'(w_sel[idx[5:0]]), exp_sel[k]);
         chk($sformatf("t1_row%0d", k), 32'(w_row[idx[5:0]]), exp_row[k]);
         chk($sformatf("t1_col%0d", k), 32'(w_col[idx[5:0]]), exp_col[k]);
         chk($sformatf("t1_data%0d", k), w_data[idx[5:0]], 32'hD000 + 32'(k));
      end
      chk("t1_done", dn - d0, 1);
      chk("t1_dim_valid", 32'(dim_valid), 1);
      chk("t1_dim_n", 32'(dim_n), 2);
      chk("t1_dim_ng", 32'(dim_ng), 3);
      chk("t1_dim_nc", 32'(dim_nc), 1);
      chk("t1_busy", 32'(busy), 0);

      // Frame 2: nc=0, n=1, ng=1
      w0 = wn; d0 = dn;
      beat(32'd1, 1'b0); beat(32'd1, 1'b0); beat(32'd0, 1'b0);
      beat(32'h0000_00C0, 1'b0); beat(32'h0000_0060, 1'b1);
      repeat (2) @(negedge clk);
      chk("t2_writes", wn - w0, 2);
      idx = w0;
      chk("t2_sel0", 32'(w_sel[idx[5:0]]), 0);
      chk("t2_data0", w_data[idx[5:0]], 32'h0000_00C0);
      idx = w0 + 1;
      chk("t2_sel1", 32'(w_sel[idx[5:0]]), 1);
      chk("t2_data1", w_data[idx[5:0]], 32'h0000_0060);
      chk("t2_done", dn - d0, 1);
      chk("t2_dim_valid", 32'(dim_valid), 1);

      // Frame 3: n=NMAX+1 rejected, drained, then a good frame
      w0 = wn; e0 = en; d0 = dn;
      beat(32'd513, 1'b0); beat(32'd1, 1'b0); beat(32'd1, 1'b0);
      chk("t3_err_pulse", 32'(err), 1);
      chk("t3_err_code", 32'(err_code), 1);
      chk("t3_busy_drain", 32'(busy), 1);
      beat(32'h11, 1'b0); beat(32'h22, 1'b0); beat(32'h33, 1'b1);
      repeat (2) @(negedge clk);
      chk("t3_writes", wn - w0, 0);
      chk("t3_err_cnt", en - e0, 1);
      chk("t3_busy_idle", 32'(busy), 0);
      chk("t3_dim_valid", 32'(dim_valid), 0);
      w0 = wn;
      beat(32'd1, 1'b0); beat(32'd1, 1'b0); beat(32'd0, 1'b0);
      beat(32'h0000_0A0A, 1'b0); beat(32'h0000_0B0B, 1'b1);
      repeat (2) @(negedge clk);
      chk("t3_after_writes", wn - w0, 2);
      chk("t3_after_done", dn - d0, 1);
      chk("t3_after_dim_valid", 32'(dim_valid), 1);

      // Frame 4: s_last on the 4th data word of 12
      w0 = wn; e0 = en; d0 = dn;
      beat(32'd2, 1'b0); beat(32'd3, 1'b0); beat(32'd1, 1'b0);
      for (int k = 0; k < 4; k++) beat(32'hE000 + 32'(k), k == 3);
      repeat (2) @(negedge clk);
      chk("t4_writes", wn - w0, 4);
      chk("t4_err_cnt", en - e0, 1);
      chk("t4_err_code", 32'(err_code), 2);
      chk("t4_dim_valid", 32'(dim_valid), 0);
      chk("t4_done", dn - d0, 0);

      // Frame 5: two extra words after the final word
      w0 = wn; e0 = en; d0 = dn;
      beat(32'd1, 1'b0); beat(32'd1, 1'b0); beat(32'd1, 1'b0);
      beat(32'hF0, 1'b0); beat(32'hF1, 1'b0); beat(32'hF2, 1'b0); beat(32'hF3, 1'b0);
      chk("t5_err_pulse", 32'(err), 1);
      chk("t5_err_code", 32'(err_code), 3);
      beat(32'hF4, 1'b0); beat(32'hF5, 1'b1);
      repeat (2) @(negedge clk);
      chk("t5_writes", wn - w0, 4);
      chk("t5_err_cnt", en - e0, 1);
      chk("t5_done", dn - d0, 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_dim_valid", 32'(dim_valid), 0);

      // Frame 6: s_valid gaps in G, then async reset mid-frame
      w0 = wn;
      beat(32'd2, 1'b0); beat(32'd2, 1'b0); beat(32'd0, 1'b0);
      beat(32'h100, 1'b0); beat(32'h101, 1'b0);
      idle($urandom_range(1, 3));
      beat(32'h200, 1'b0);
      idle($urandom_range(1, 3));
      beat(32'h201, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_writes_before_rst", wn - w0, 4);
      chk("t6_rst_wr_en", 32'(wr_en), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_err_code", 32'(err_code), 0);
      chk("t6_rst_dim_n", 32'(dim_n), 0);
      chk("t6_rst_dim_valid", 32'(dim_valid), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      w0 = wn; d0 = dn;
      beat(32'd2, 1'b0); beat(32'd2, 1'b0); beat(32'd0, 1'b0);
      for (int k = 0; k < 6; k++) beat(32'h300 + 32'(k), k == 5);
      repeat (2) @(negedge clk);
      chk("t6_writes", wn - w0, 6);
      idx = w0 + 5;
      chk("t6_last_sel", 32'(w_sel[idx[5:0]]), 1);
      chk("t6_last_row", 32'(w_row[idx[5:0]]), 1);
      chk("t6_last_col", 32'(w_col[idx[5:0]]), 1);
      chk("t6_last_data", w_data[idx[5:0]], 32'h305);
      chk("t6_done", dn - d0, 1);
      chk("t6_dim_valid", 32'(dim_valid), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
